// File: rtl/freq_mon_pkg.sv
// Shared types and constants for the multi-channel frequency monitor.
package freq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        WAIT   = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam int unsigned MIN_GATE     = 2;
    localparam int unsigned DEFAULT_GATE = 40000000;

endpackage : freq_mon_pkg

// File: rtl/freq_mon_channel.sv
// One measurement channel: Gray decode, baseline, modular delta, limit check, sticky alarm.
module freq_mon_channel
    import freq_mon_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_40MHz,
    input  logic                 reset,
    input  logic                 prime_i,
    input  logic                 capture_i,
    input  logic [CNT_WIDTH-1:0] gray_i,
    input  logic [CNT_WIDTH-1:0] f_min_i,
    input  logic [CNT_WIDTH-1:0] f_max_i,
    input  logic                 alarm_clr_i,
    output logic [CNT_WIDTH-1:0] frequency_o,
    output logic                 in_range_o,
    output logic                 alarm_o
);

    logic [CNT_WIDTH-1:0] bin_c;
    logic [CNT_WIDTH-1:0] delta_c;
    logic                 in_lim_c;

    logic [CNT_WIDTH-1:0] baseline_q, baseline_d;
    logic [CNT_WIDTH-1:0] result_q,   result_d;
    logic                 in_range_q, in_range_d;
    logic                 alarm_q,    alarm_d;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_c = '0;
        bin_c[CNT_WIDTH-1] = gray_i[CNT_WIDTH-1];
        for (int i = CNT_WIDTH - 2; i >= 0; i--) begin
            bin_c[i] = bin_c[i+1] ^ gray_i[i];
        end
    end

    // Modular delta handles counter wrap; limits compare on the fresh delta.
    always_comb begin
        delta_c  = bin_c - baseline_q;
        in_lim_c = (f_min_i <= delta_c) && (delta_c <= f_max_i);
    end

    // Next-state for baseline, result, range status and sticky alarm (set beats clear).
    always_comb begin
        baseline_d = baseline_q;
        result_d   = result_q;
        in_range_d = in_range_q;
        alarm_d    = alarm_q;
        if (prime_i || capture_i) begin
            baseline_d = bin_c;
        end
        if (capture_i) begin
            result_d   = delta_c;
            in_range_d = in_lim_c;
        end
        if (capture_i && !in_lim_c) begin
            alarm_d = 1'b1;
        end else if (alarm_clr_i) begin
            alarm_d = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            baseline_q <= '0;
            result_q   <= '0;
            in_range_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            baseline_q <= baseline_d;
            result_q   <= result_d;
            in_range_q <= in_range_d;
            alarm_q    <= alarm_d;
        end
    end

    assign frequency_o = result_q;
    assign in_range_o  = in_range_q;
    assign alarm_o     = alarm_q;

endmodule : freq_mon_channel

// File: rtl/multi_frequency_monitor.sv
// Multi-channel delta-based frequency monitor with contiguous programmable gates.
module multi_frequency_monitor
    import freq_mon_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned GATE_WIDTH = 32
) (
    input  logic                        clk_40MHz,
    input  logic                        reset,
    input  logic                        enable_i,
    input  logic [NUM_CH*CNT_WIDTH-1:0] gray_cnt_i,
    input  logic [GATE_WIDTH-1:0]       gate_len_i,
    input  logic [CNT_WIDTH-1:0]        f_min_i,
    input  logic [CNT_WIDTH-1:0]        f_max_i,
    input  logic                        alarm_clr_i,
    output logic [NUM_CH*CNT_WIDTH-1:0] frequency_o,
    output logic                        valid_o,
    output logic [NUM_CH-1:0]           in_range_o,
    output logic [NUM_CH-1:0]           alarm_o
);

    localparam logic [GATE_WIDTH-1:0] GATE_MIN = GATE_WIDTH'(MIN_GATE);
    localparam logic [GATE_WIDTH-1:0] GATE_ONE = GATE_WIDTH'(1);

    state_t                state_q, state_d;
    logic [GATE_WIDTH-1:0] gate_q,  gate_d;
    logic [GATE_WIDTH-1:0] cnt_q,   cnt_d;
    logic                  valid_q, valid_d;

    logic [GATE_WIDTH-1:0] gate_eff_c;
    logic                  prime_c;
    logic                  capture_c;

    // Gate lengths below the minimum are clamped so a window always has a WAIT cycle.
    assign gate_eff_c = (gate_len_i < GATE_MIN) ? GATE_MIN : gate_len_i;
    assign prime_c    = (state_q == PRIME);
    assign capture_c  = (state_q == SAMPLE);

    // Sequencer: PRIME loads baselines, WAIT counts G-1 cycles, SAMPLE closes and reopens a window.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                gate_d  = gate_eff_c;
                cnt_d   = GATE_ONE;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == (gate_q - GATE_ONE)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + GATE_ONE;
                end
            end
            SAMPLE: begin
                gate_d  = gate_eff_c;
                cnt_d   = GATE_ONE;
                valid_d = 1'b1;
                state_d = enable_i ? WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

    // One measurement slice per channel, all strobed by the shared sequencer.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        freq_mon_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_channel (
            .clk_40MHz   (clk_40MHz),
            .reset       (reset),
            .prime_i     (prime_c),
            .capture_i   (capture_c),
            .gray_i      (gray_cnt_i[ch*CNT_WIDTH +: CNT_WIDTH]),
            .f_min_i     (f_min_i),
            .f_max_i     (f_max_i),
            .alarm_clr_i (alarm_clr_i),
            .frequency_o (frequency_o[ch*CNT_WIDTH +: CNT_WIDTH]),
            .in_range_o  (in_range_o[ch]),
            .alarm_o     (alarm_o[ch])
        );
    end

endmodule : multi_frequency_monitor

// File: tb/tb_multi_frequency_monitor.sv
// Directed bench for multi_frequency_monitor: four Gray counters with per-channel step sizes.
module tb_multi_frequency_monitor;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int GW  = 32;

    logic                clk;
    logic                reset;
    logic                enable;
    logic [NCH*CW-1:0]   gray_cnt;
    logic [GW-1:0]       gate_len;
    logic [CW-1:0]       f_min;
    logic [CW-1:0]       f_max;
    logic                alarm_clr;
    logic [NCH*CW-1:0]   frequency;
    logic                valid;
    logic [NCH-1:0]      in_range;
    logic [NCH-1:0]      alarm;

    logic [CW-1:0] bcnt [NCH];
    logic [CW-1:0] inc  [NCH];

    int checks   = 0;
    int failures = 0;

    multi_frequency_monitor #(
        .NUM_CH     (NCH),
        .CNT_WIDTH  (CW),
        .GATE_WIDTH (GW)
    ) dut (
        .clk_40MHz   (clk),
        .reset       (reset),
        .enable_i    (enable),
        .gray_cnt_i  (gray_cnt),
        .gate_len_i  (gate_len),
        .f_min_i     (f_min),
        .f_max_i     (f_max),
        .alarm_clr_i (alarm_clr),
        .frequency_o (frequency),
        .valid_o     (valid),
        .in_range_o  (in_range),
        .alarm_o     (alarm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running source counters advance on the falling edge, away from DUT sampling.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                bcnt[i] = bcnt[i] + inc[i];
                gray_cnt[i*CW +: CW] = bcnt[i] ^ (bcnt[i] >> 1);
            end
        end
    end

    function automatic logic [CW-1:0] freq_of(input int ch);
        freq_of = frequency[ch*CW +: CW];
    endfunction

    task automatic set_incs(input logic [CW-1:0] a, input logic [CW-1:0] b,
                            input logic [CW-1:0] c, input logic [CW-1:0] d);
        inc[0] = a; inc[1] = b; inc[2] = c; inc[3] = d;
    endtask

    // Waits (bounded) for the next valid pulse, returning the number of rising edges it took.
    task automatic wait_valid(input string name, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!valid && cyc < max_cyc);
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL %s: valid_o timeout after %0d cycles, got %b expected 1", name, cyc, valid);
        end
    endtask

    task automatic check_all_freq(input string name, input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                                  input logic [CW-1:0] e2, input logic [CW-1:0] e3);
        logic [CW-1:0] exp_f [NCH];
        exp_f[0] = e0; exp_f[1] = e1; exp_f[2] = e2; exp_f[3] = e3;
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (freq_of(i) !== exp_f[i]) begin
                failures++;
                $display("FAIL %s ch%0d: frequency got %0d expected %0d", name, i, freq_of(i), exp_f[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frequency !== '0 || valid !== 1'b0 || in_range !== 4'h0 || alarm !== 4'h0) begin
            failures++;
            $display("FAIL reset: freq=%h valid=%b in_range=%b alarm=%b expected all zero",
                     frequency, valid, in_range, alarm);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc;
        set_incs(2, 2, 2, 2);
        gate_len = 100;
        f_min    = 0;
        f_max    = 1000;
        enable   = 1'b1;
        wait_valid("basic_first", 300, cyc);
        checks++;
        if (cyc != 102) begin
            failures++;
            $display("FAIL basic_first_latency: got %0d edges expected 102", cyc);
        end
        check_all_freq("basic_first", 200, 200, 200, 200);
        checks++;
        if (in_range !== 4'hF || alarm !== 4'h0) begin
            failures++;
            $display("FAIL basic_status: in_range=%b alarm=%b expected 1111 0000", in_range, alarm);
        end
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse_width: valid got %b expected 0", valid);
        end
        checks++;
        if (freq_of(3) !== 200) begin
            failures++;
            $display("FAIL basic_hold: frequency ch3 got %0d expected 200", freq_of(3));
        end
        wait_valid("basic_second", 300, cyc);
        checks++;
        if (cyc != 99) begin
            failures++;
            $display("FAIL basic_period: got %0d edges after hold cycle expected 99", cyc);
        end
        check_all_freq("basic_second", 200, 200, 200, 200);
    endtask

    task automatic test_enable_and_wrap();
        int cyc;
        int extra;
        enable = 1'b0;
        wait_valid("disable_last", 300, cyc);
        checks++;
        if (cyc != 100) begin
            failures++;
            $display("FAIL disable_last_window: got %0d edges expected 100", cyc);
        end
        extra = 0;
        for (int k = 0; k < 250; k++) begin
            @(posedge clk); #1;
            if (valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL disable_quiet: got %0d valid pulses expected 0", extra);
        end
        bcnt[1] = 32'hFFFF_FFCE;
        inc[1]  = 3;
        enable  = 1'b1;
        wait_valid("reenable", 300, cyc);
        checks++;
        if (cyc != 102) begin
            failures++;
            $display("FAIL reenable_latency: got %0d edges expected 102", cyc);
        end
        check_all_freq("wrap_first", 200, 300, 200, 200);
        wait_valid("wrap_second", 300, cyc);
        check_all_freq("wrap_second", 200, 300, 200, 200);
    endtask

    task automatic test_alarm();
        int cyc;
        set_incs(1, 1, 2, 1);
        f_max = 150;
        wait_valid("alarm", 300, cyc);
        check_all_freq("alarm", 100, 100, 200, 100);
        checks++;
        if (in_range !== 4'b1011 || alarm !== 4'b0100) begin
            failures++;
            $display("FAIL alarm_set: in_range=%b alarm=%b expected 1011 0100", in_range, alarm);
        end
    endtask

    task automatic test_alarm_clear();
        int cyc;
        inc[2]    = 1;
        alarm_clr = 1'b1;
        @(posedge clk); #1;
        alarm_clr = 1'b0;
        checks++;
        if (alarm !== 4'b0000) begin
            failures++;
            $display("FAIL alarm_clear: alarm got %b expected 0000", alarm);
        end
        wait_valid("clear_window", 300, cyc);
        check_all_freq("clear_window", 100, 100, 100, 100);
        checks++;
        if (in_range !== 4'hF || alarm !== 4'h0) begin
            failures++;
            $display("FAIL clear_status: in_range=%b alarm=%b expected 1111 0000", in_range, alarm);
        end
        // Clear asserted on the very edge that registers an out-of-range result.
        inc[2] = 2;
        repeat (99) @(posedge clk);
        #1;
        alarm_clr = 1'b1;
        @(posedge clk); #1;
        alarm_clr = 1'b0;
        checks++;
        if (valid !== 1'b1 || alarm !== 4'b0100 || in_range !== 4'b1011) begin
            failures++;
            $display("FAIL alarm_priority: valid=%b alarm=%b in_range=%b expected 1 0100 1011",
                     valid, alarm, in_range);
        end
    endtask

    task automatic test_gate_change();
        int cyc;
        set_incs(2, 2, 2, 2);
        f_max = 1000;
        alarm_clr = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        alarm_clr = 1'b0;
        gate_len  = 50;
        wait_valid("gate_current", 300, cyc);
        checks++;
        if (cyc != 70) begin
            failures++;
            $display("FAIL gate_current_len: got %0d edges expected 70", cyc);
        end
        check_all_freq("gate_current", 200, 200, 200, 200);
        wait_valid("gate_next", 300, cyc);
        checks++;
        if (cyc != 50) begin
            failures++;
            $display("FAIL gate_next_len: got %0d edges expected 50", cyc);
        end
        check_all_freq("gate_next", 100, 100, 100, 100);
        gate_len = 0;
        wait_valid("gate_zero_pending", 300, cyc);
        check_all_freq("gate_zero_pending", 100, 100, 100, 100);
        wait_valid("gate_zero", 300, cyc);
        checks++;
        if (cyc != 2) begin
            failures++;
            $display("FAIL gate_zero_len: got %0d edges expected 2", cyc);
        end
        check_all_freq("gate_zero", 4, 4, 4, 4);
        checks++;
        if (in_range !== 4'hF || alarm !== 4'h0) begin
            failures++;
            $display("FAIL gate_zero_status: in_range=%b alarm=%b expected 1111 0000", in_range, alarm);
        end
    endtask

    task automatic test_inverted_limits();
        int cyc;
        f_min = 5;
        f_max = 3;
        wait_valid("inverted", 300, cyc);
        check_all_freq("inverted", 4, 4, 4, 4);
        checks++;
        if (in_range !== 4'h0 || alarm !== 4'hF) begin
            failures++;
            $display("FAIL inverted_limits: in_range=%b alarm=%b expected 0000 1111", in_range, alarm);
        end
    endtask

    task automatic test_reset_mid_window();
        int cyc;
        int extra;
        gate_len = 100;
        wait_valid("pre_reset", 300, cyc);
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (frequency !== '0 || valid !== 1'b0 || in_range !== 4'h0 || alarm !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid: freq=%h valid=%b in_range=%b alarm=%b expected all zero",
                     frequency, valid, in_range, alarm);
        end
        extra = 0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL reset_quiet: got %0d valid pulses expected 0", extra);
        end
        f_min = 0;
        f_max = 1000;
        reset = 1'b0;
        wait_valid("post_reset", 300, cyc);
        checks++;
        if (cyc != 102) begin
            failures++;
            $display("FAIL post_reset_latency: got %0d edges expected 102", cyc);
        end
        check_all_freq("post_reset", 200, 200, 200, 200);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        gate_len  = 100;
        f_min     = 0;
        f_max     = 1000;
        alarm_clr = 1'b0;
        gray_cnt  = '0;
        for (int i = 0; i < NCH; i++) begin
            bcnt[i] = '0;
            inc[i]  = '0;
        end
        test_reset();
        test_basic();
        test_enable_and_wrap();
        test_alarm();
        test_alarm_clear();
        test_gate_change();
        test_inverted_limits();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multi_frequency_monitor

// File: doc/multi_frequency_monitor.md
Name: multi_frequency_monitor

Overview:
- Multi-channel successor to the single-channel laser frequency counter.
- Takes NUM_CH free-running Gray-coded counts, each already synchronized into the 40 MHz domain, and measures each channel's count increment over a runtime-programmable gate.
- Measurement is delta-based: no counter reset crosses clock domains, and windows are back-to-back with no dead time.
- Checks every result against min/max limits and raises a sticky alarm per channel. Sits beside the oscillator monitors and feeds the status register bank.

Parameters:
- NUM_CH, 4: number of measured channels.
- CNT_WIDTH, 32: width of each Gray count and of each frequency result.
- GATE_WIDTH, 32: width of gate length input and internal gate counter.

Ports:
- clk_40MHz  in  1  fixed crystal reference clock; sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  run measurements while high.
- gray_cnt_i  in  NUM_CH*CNT_WIDTH  synchronized free-running Gray counts; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- gate_len_i  in  GATE_WIDTH  gate length in clk_40MHz cycles (40000000 gives Hz).
- f_min_i  in  CNT_WIDTH  lower limit, shared by all channels.
- f_max_i  in  CNT_WIDTH  upper limit, shared by all channels.
- alarm_clr_i  in  1  clears all sticky alarms.
- frequency_o  out  NUM_CH*CNT_WIDTH  last result per channel, same packing as gray_cnt_i.
- valid_o  out  1  one-cycle pulse: new results present.
- in_range_o  out  NUM_CH  per-channel range status of the last result, non-sticky.
- alarm_o  out  NUM_CH  sticky out-of-range flag per channel.

Behaviour:
- Reset values:
  - frequency_o = 0, valid_o = 0, in_range_o = 0, alarm_o = 0.
  - All baselines = 0; gate counter = 0; state = IDLE.
- Gray-to-binary conversion per channel is combinational on gray_cnt_i (bin_i).
- FSM states: IDLE, PRIME, WAIT, SAMPLE.
  - IDLE: stays in IDLE while enable_i = 0; goes to PRIME when enable_i = 1.
  - PRIME: baseline_i <= bin_i; G <= max(gate_len_i, 2); cnt <= 1; next state WAIT.
  - WAIT: if cnt == G-1, go to SAMPLE; otherwise cnt <= cnt+1.
  - SAMPLE: delta_i = bin_i - baseline_i modulo 2^CNT_WIDTH; baseline_i <= bin_i; G <= max(gate_len_i, 2); cnt <= 1.
  - From SAMPLE: next state is WAIT if enable_i = 1, else IDLE.
- Timing:
  - PRIME at cycle t produces SAMPLE at t+G, then t+2G, and so on.
  - Each window is exactly G cycles, and windows are contiguous.
- Gate length:
  - Latched only in PRIME or SAMPLE.
  - A mid-window change takes effect from the next window.
  - Values 0 and 1 are clamped to 2.
- Outputs registered from SAMPLE (latency 1). In the cycle after SAMPLE:
  - valid_o = 1.
  - frequency_o_i = delta_i.
  - in_range_o_i = (f_min_i <= delta_i <= f_max_i).
- frequency_o and in_range_o hold between valid pulses.
- Wrap-around: modular subtraction gives the correct delta across a counter wrap. Deltas >= 2^CNT_WIDTH per window alias; this is not detected.
- Alarms:
  - alarm_o_i is set on any valid result that is out of range.
  - Cleared by alarm_clr_i.
  - Set wins over clear in the same cycle.
- If f_min_i > f_max_i, every result is out of range.
- enable_i = 0 during WAIT:
  - The window completes its SAMPLE, then the FSM goes to IDLE.
  - Re-enable starts at PRIME; no result spans the idle gap.
- Reset mid-window: everything returns to reset values immediately; no valid_o.
- First result after enable arrives G+1 cycles after PRIME. There is no bogus result from the zero baseline.

Decomposition:
- Package freq_mon_pkg holds:
  - state_t enum {IDLE, PRIME, WAIT, SAMPLE}.
  - MIN_GATE = 2.
  - DEFAULT_GATE = 40000000.
- Sub-module freq_mon_channel, instantiated NUM_CH times by generate. Each instance contains:
  - existing gray2bin;
  - baseline register;
  - modular subtractor;
  - limit compare;
  - result, in_range and sticky alarm registers;
  - capture and prime strobes from the top-level FSM.

Test Plan:
- Basic measurement: G = 100, all channels' bench counters +2/clk, limits 0..1000 -> valid_o every 100 cycles, frequency_o = 200 on all channels, in_range_o = all 1, alarm_o = 0.
- Wrap-around: channel 1 starts at 2^32-50 and increments +3/clk, G = 100 -> result 300 on every window including the wrapping one.
- Alarm: f_max = 150 with ch2 at +2/clk -> alarm_o[2] = 1, in_range_o[2] = 0.
- Alarm clear and priority:
  - Lower ch2 to +1/clk and pulse alarm_clr_i -> alarm cleared, in_range_o[2] = 1.
  - Pulse clr in the same cycle as an out-of-range result -> alarm stays 1.
- Gate change: gate_len_i 100 -> 50 mid-window -> current window still 100 cycles (result 200), next windows 50 cycles (result 100). gate_len_i = 0 -> windows of 2 cycles (result 4).
- Enable and reset:
  - enable_i low mid-window -> one more valid_o, then none.
  - Re-enable -> first valid_o exactly G+1 cycles after PRIME.
  - Async reset mid-window -> outputs 0 immediately, no valid_o.
